sar_capture: RTL and testbench

SAR_CAPTURE -- requirements
Module: sar_capture

---
 rtl/sar_pkg.sv | 15 +
 rtl/sar_capture_fifo.sv | 69 ++++++
 rtl/sar_capture.sv | 153 +++++++++++++++
 tb/tb_sar_capture.sv | 203 ++++++++++++++++++++
 4 files changed

// File: rtl/sar_pkg.sv
// Shared definitions for the SAR capture block.
//   - state_e  : capture FSM state encoding
//   - SAR_NBITS: default SAR result width
package sar_pkg;

  localparam int SAR_NBITS = 8;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_WAIT  = 2'd2,
    ST_GAP   = 2'd3
  } state_e;

endpackage

// File: rtl/sar_capture_fifo.sv
// Result FIFO for sar_capture.
// Ports:
//   clk_i, rst_ni   : clock, asynchronous active-low reset
//   push_i, wdata_i : write request and data (ignored while full unless popping)
//   pop_i           : read request (ignored while empty)
//   rdata_o         : oldest entry
//   full_o, empty_o : occupancy status
module sar_capture_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             push_i,
  input  logic [WIDTH-1:0] wdata_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] rdata_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [AW:0] FULL_C = (AW + 1)'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [AW:0]      count_q, count_d;
  logic             push_ok_s, pop_ok_s;

  assign full_o  = (count_q == FULL_C);
  assign empty_o = (count_q == '0);
  assign rdata_o = mem_q[rd_ptr_q];

  // A pop frees a slot in the same cycle, so a push into a full FIFO is accepted then.
  assign pop_ok_s  = pop_i & ~empty_o;
  assign push_ok_s = push_i & (~full_o | pop_ok_s);

  // Occupancy next-state.
  always_comb begin
    count_d = count_q;
    case ({push_ok_s, pop_ok_s})
      2'b10:   count_d = count_q + (AW + 1)'(1);
      2'b01:   count_d = count_q - (AW + 1)'(1);
      default: count_d = count_q;
    endcase
  end

  // Storage, pointers (power-of-two depth, so they wrap naturally) and occupancy.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push_ok_s) begin
        mem_q[wr_ptr_q] <= wdata_i;
        wr_ptr_q        <= wr_ptr_q + AW'(1);
      end
      if (pop_ok_s) begin
        rd_ptr_q <= rd_ptr_q + AW'(1);
      end
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/sar_capture.sv
// SAR conversion sequencer and result capture.
// Ports:
//   clk_i, rst_ni            : clock, asynchronous active-low reset
//   en_i, trig_i, interval_i : continuous enable, single-shot request, idle gap length
//   go_o, busy_o             : conversion request pulse, conversion in flight
//   valid_i, resultp_i/n_i   : SAR completion and decided-one / decided-zero vectors
//   dout_o, dout_valid_o,
//   dout_ready_i             : captured-result stream (oldest first)
//   clr_flags_i, err_*_o     : sticky error flags and their clear
module sar_capture
  import sar_pkg::*;
#(
  parameter int NBITS = SAR_NBITS,
  parameter int DEPTH = 4,
  parameter int TMO   = NBITS + 4
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             en_i,
  input  logic             trig_i,
  input  logic [15:0]      interval_i,
  output logic             go_o,
  input  logic             valid_i,
  input  logic [NBITS-1:0] resultp_i,
  input  logic [NBITS-1:0] resultn_i,
  output logic [NBITS-1:0] dout_o,
  output logic             dout_valid_o,
  input  logic             dout_ready_i,
  output logic             busy_o,
  input  logic             clr_flags_i,
  output logic             err_ovf_o,
  output logic             err_cons_o,
  output logic             err_tmo_o
);

  localparam logic [15:0] TMO_C = 16'(TMO);

  state_e      state_q, state_d;
  logic [15:0] cnt_q, cnt_d;
  logic        go_q, busy_q;
  logic        err_ovf_q, err_cons_q, err_tmo_q;
  logic        err_ovf_d, err_cons_d, err_tmo_d;
  logic        push_s, tmo_s, pop_s, ovf_s, cons_s;
  logic        full_s, empty_s;

  // Next-state: one counter serves as the VALID timeout in WAIT and the idle gap in GAP.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    push_s  = 1'b0;
    tmo_s   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (en_i || trig_i) state_d = ST_START;
        else                state_d = ST_IDLE;
      end
      ST_START: begin
        state_d = ST_WAIT;
        cnt_d   = TMO_C;
      end
      ST_WAIT: begin
        if (valid_i) begin
          push_s = 1'b1;
          if (!en_i) begin
            state_d = ST_IDLE;
            cnt_d   = 16'd0;
          end else if (interval_i == 16'd0) begin
            state_d = ST_START;
          end else begin
            state_d = ST_GAP;
            cnt_d   = interval_i;
          end
        end else if (cnt_q <= 16'd1) begin
          // Last allowed WAIT cycle passed without VALID.
          tmo_s   = 1'b1;
          state_d = ST_IDLE;
          cnt_d   = 16'd0;
        end else begin
          cnt_d = cnt_q - 16'd1;
        end
      end
      ST_GAP: begin
        if (!en_i) begin
          state_d = ST_IDLE;
          cnt_d   = 16'd0;
        end else if (cnt_q <= 16'd1) begin
          state_d = ST_START;
          cnt_d   = 16'd0;
        end else begin
          cnt_d = cnt_q - 16'd1;
        end
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = 16'd0;
      end
    endcase
  end

  assign pop_s  = ~empty_s & dout_ready_i;
  assign ovf_s  = push_s & full_s & ~pop_s;
  assign cons_s = push_s & ((resultp_i ^ resultn_i) != {NBITS{1'b1}});

  // Sticky flags: a set event in the same cycle outranks the clear.
  always_comb begin
    err_ovf_d  = ovf_s  ? 1'b1 : (clr_flags_i ? 1'b0 : err_ovf_q);
    err_cons_d = cons_s ? 1'b1 : (clr_flags_i ? 1'b0 : err_cons_q);
    err_tmo_d  = tmo_s  ? 1'b1 : (clr_flags_i ? 1'b0 : err_tmo_q);
  end

  // State, counter, registered status outputs and flags.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= ST_IDLE;
      cnt_q      <= 16'd0;
      go_q       <= 1'b0;
      busy_q     <= 1'b0;
      err_ovf_q  <= 1'b0;
      err_cons_q <= 1'b0;
      err_tmo_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      go_q       <= (state_d == ST_START);
      busy_q     <= (state_d == ST_START) || (state_d == ST_WAIT);
      err_ovf_q  <= err_ovf_d;
      err_cons_q <= err_cons_d;
      err_tmo_q  <= err_tmo_d;
    end
  end

  sar_capture_fifo #(
    .WIDTH (NBITS),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .push_i  (push_s),
    .wdata_i (resultp_i),
    .pop_i   (pop_s),
    .rdata_o (dout_o),
    .full_o  (full_s),
    .empty_o (empty_s)
  );

  assign go_o         = go_q;
  assign busy_o       = busy_q;
  assign dout_valid_o = ~empty_s;
  assign err_ovf_o    = err_ovf_q;
  assign err_cons_o   = err_cons_q;
  assign err_tmo_o    = err_tmo_q;

endmodule

// File: tb/tb_sar_capture.sv
// Self-checking bench for sar_capture: a SAR responder answers each GO after a
// chosen number of WAIT cycles; a queue-based model predicts the result stream
// and sticky flags.
module tb_sar_capture;

  localparam int NB  = 8;
  localparam int DP  = 4;
  localparam int TMO = NB + 4;

  logic          clk = 1'b0;
  logic          rst_n = 1'b1;
  logic          en = 1'b0, trig = 1'b0, valid = 1'b0, ready = 1'b0, clr = 1'b0;
  logic [15:0]   interval = 16'd0;
  logic [NB-1:0] resp = '0, resn = '0;
  logic          go, dout_valid, busy, err_ovf, err_cons, err_tmo;
  logic [NB-1:0] dout;

  sar_capture #(.NBITS(NB), .DEPTH(DP), .TMO(TMO)) dut (
    .clk_i(clk), .rst_ni(rst_n), .en_i(en), .trig_i(trig), .interval_i(interval),
    .go_o(go), .valid_i(valid), .resultp_i(resp), .resultn_i(resn),
    .dout_o(dout), .dout_valid_o(dout_valid), .dout_ready_i(ready), .busy_o(busy),
    .clr_flags_i(clr), .err_ovf_o(err_ovf), .err_cons_o(err_cons), .err_tmo_o(err_tmo)
  );

  always #5 clk = ~clk;

  int            n_cmp = 0, n_bad = 0;
  logic [NB-1:0] mq[$];
  bit            m_ovf = 0, m_cons = 0, m_tmo = 0;
  bit            waiting = 0, go_prev = 0;
  int            widx = 0, resp_lat = 0, cyc = 0, n_cap = 0;
  logic [NB-1:0] nxt_p = '0, nxt_n = '0;
  int            go_log[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock cycle: respond to the SAR handshake, check outputs, advance model.
  task automatic cycle();
    bit push, pop, ovf, tmo_ev;
    push = 0; tmo_ev = 0;
    if (go_prev) begin waiting = 1; widx = 1; end
    else if (waiting) widx++;
    valid = 1'b0;
    if (waiting && resp_lat != 0 && widx == resp_lat) begin
      valid = 1'b1; resp = nxt_p; resn = nxt_n; push = 1;
    end else if (waiting && widx == TMO) begin
      tmo_ev = 1;
    end
    chk("busy", busy, go | waiting);
    if (waiting) chk("go_in_wait", go, 1'b0);
    chk("dout_valid", dout_valid, mq.size() != 0);
    if (mq.size() != 0) chk("dout", dout, mq[0]);
    chk("err_ovf", err_ovf, m_ovf);
    chk("err_cons", err_cons, m_cons);
    chk("err_tmo", err_tmo, m_tmo);
    pop = (mq.size() != 0) && ready;
    ovf = push && (mq.size() == DP) && !pop;
    m_ovf  = ovf ? 1 : (clr ? 0 : m_ovf);
    m_cons = (push && ((nxt_p ^ nxt_n) != 8'hFF)) ? 1 : (clr ? 0 : m_cons);
    m_tmo  = tmo_ev ? 1 : (clr ? 0 : m_tmo);
    if (pop) void'(mq.pop_front());
    if (push && !ovf) mq.push_back(nxt_p);
    if (push) n_cap++;
    if (push || tmo_ev) waiting = 0;
    go_prev = go;
    if (go) go_log.push_back(cyc);
    @(posedge clk); #1;
    cyc++;
    trig = 1'b0;
    clr  = 1'b0;
    valid = 1'b0;
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) cycle();
  endtask

  initial begin
    int n0, start;
    bit reached;
    // Reset state.
    #1 rst_n = 1'b0;
    #1;
    chk("rst_go", go, 1'b0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_dout_valid", dout_valid, 1'b0);
    chk("rst_dout", dout, 8'h00);
    chk("rst_flags", {err_ovf, err_cons, err_tmo}, 3'b000);
    @(posedge clk); #1;
    rst_n = 1'b1;
    run(2);

    // Single-shot with consistent vectors.
    nxt_p = 8'hA5; nxt_n = 8'h5A; resp_lat = NB + 2;
    n0 = go_log.size();
    trig = 1'b1;
    run(NB + 8);
    chk("trig_go_count", go_log.size() - n0, 1);
    chk("trig_cons", err_cons, 1'b0);
    ready = 1'b1;
    run(3);

    // Continuous conversion with periodic GO.
    en = 1'b1; interval = 16'd3; resp_lat = NB + 3;
    go_log.delete();
    for (int k = 0; k < 6; k++) begin
      nxt_p = 8'($urandom); nxt_n = ~nxt_p;
      run(NB + 7);
    end
    en = 1'b0;
    run(NB + 8);
    chk("period_go_count", go_log.size() >= 5, 1'b1);
    for (int i = 1; i < go_log.size(); i++)
      chk("go_spacing", go_log[i] - go_log[i-1], NB + 7);

    // Overflow: five back-to-back captures into a 4-deep FIFO, no draining.
    ready = 1'b0; en = 1'b1; interval = 16'd0; resp_lat = 3;
    n0 = n_cap;
    for (int i = 0; i < 200 && n_cap - n0 < 5; i++) begin
      nxt_p = 8'(8'h10 + n_cap - n0); nxt_n = ~nxt_p;
      cycle();
    end
    en = 1'b0;
    chk("ovf_captures", n_cap - n0, 5);
    run(6);
    chk("ovf_flag", err_ovf, 1'b1);
    chk("ovf_stored", mq.size(), DP);
    clr = 1'b1;
    run(2);
    chk("ovf_cleared", err_ovf, 1'b0);
    ready = 1'b1;
    run(8);

    // Timeout: GO with no VALID.
    resp_lat = 0;
    trig = 1'b1;
    run(TMO + 4);
    chk("tmo_flag", err_tmo, 1'b1);
    chk("tmo_idle", busy, 1'b0);
    chk("tmo_empty", dout_valid, 1'b0);
    clr = 1'b1;
    run(2);

    // Inconsistent vectors, result kept in the FIFO.
    ready = 1'b0; resp_lat = 4; nxt_p = 8'hF0; nxt_n = 8'h0E;
    trig = 1'b1;
    run(8);
    chk("cons_flag", err_cons, 1'b1);
    chk("cons_dout", dout, 8'hF0);

    // Reset in the middle of WAIT, then a stray VALID.
    resp_lat = 0;
    trig = 1'b1;
    reached = 0;
    for (int i = 0; i < 30 && !reached; i++) begin
      cycle();
      reached = waiting && widx >= 2;
    end
    chk("rst_reach_wait", reached, 1'b1);
    rst_n = 1'b0;
    #1;
    chk("rst_mid_go", go, 1'b0);
    chk("rst_mid_busy", busy, 1'b0);
    chk("rst_mid_dout_valid", dout_valid, 1'b0);
    chk("rst_mid_dout", dout, 8'h00);
    chk("rst_mid_flags", {err_ovf, err_cons, err_tmo}, 3'b000);
    mq.delete(); m_ovf = 0; m_cons = 0; m_tmo = 0; waiting = 0; go_prev = 0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    valid = 1'b1; resp = 8'h33; resn = 8'h00;
    @(posedge clk); #1;
    valid = 1'b0;
    run(4);

    // Randomized traffic against the model.
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(0, 15) == 0) en = ~en;
      trig  = ($urandom_range(0, 7) == 0);
      ready = ($urandom_range(0, 1) == 1);
      clr   = ($urandom_range(0, 24) == 0);
      if ($urandom_range(0, 31) == 0) interval = 16'($urandom_range(0, 4));
      if (go) resp_lat = ($urandom_range(0, 7) == 0) ? 0 : int'($urandom_range(1, TMO));
      nxt_p = 8'($urandom);
      nxt_n = ($urandom_range(0, 3) == 0) ? 8'($urandom) : ~nxt_p;
      cycle();
    end

    // Drain.
    en = 1'b0; ready = 1'b1;
    run(TMO + 12);
    chk("final_empty", dout_valid, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
